// File: rtl/fft_pkg.sv
// fft_pkg: FSM state type and latency helpers shared by the SDF FFT sequencer.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   function automatic int stage_lat(input int s, input int n);
      return (n >> (s + 1)) + 1;
   endfunction

   // Advances from stream start before stage s sees its first sample.
   function automatic int stage_dly(input int s, input int n);
      int d;
      d = 0;
      for (int i = 0; i < s; i++) d += stage_lat(i, n);
      return d;
   endfunction

   function automatic int total_lat(input int n);
      return stage_dly($clog2(n), n);
   endfunction

endpackage

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: per-stage start delay, position counter and control bit.
// Twiddle address output present only with FFT_SDF_CTRL_TWIDDLE_EN.
module fft_stage_seq
   import fft_pkg::*;
#(
   parameter int N     = 16,
   parameter int LOG2N = 4,
   parameter int S     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             clr,
   output logic             ctrl
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
   ,
   output logic [LOG2N-1:0] tw_addr
`endif
);
   localparam int D  = stage_dly(S, N);
   localparam int DW = $clog2(D + 2);
   localparam int B  = LOG2N - 1 - S;
   localparam logic [DW-1:0] DV = DW'(D);
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
   localparam logic [LOG2N-1:0] TW_MASK = LOG2N'((N >> (S + 1)) - 1);
`endif

   logic [DW-1:0]    dcnt;
   logic             started;
   logic             active;
   logic [LOG2N-1:0] pos;
   logic [LOG2N-1:0] pos_nxt;

   // Counting begins on the advance that reaches the start delay.
   assign active  = started | (dcnt == DV);
   assign pos_nxt = pos + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dcnt    <= '0;
         started <= 1'b0;
         pos     <= '0;
         ctrl    <= 1'b0;
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
         tw_addr <= '0;
`endif
      end else if (clr) begin
         dcnt    <= '0;
         started <= 1'b0;
         pos     <= '0;
         ctrl    <= 1'b0;
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
         tw_addr <= '0;
`endif
      end else if (adv) begin
         if (!started) begin
            if (dcnt == DV) started <= 1'b1;
            else            dcnt    <= dcnt + 1'b1;
         end
         if (active) begin
            pos  <= pos_nxt;
            ctrl <= pos_nxt[B];
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
            tw_addr <= pos_nxt[B] ?
                       LOG2N'((pos_nxt & TW_MASK) << S) : '0;
`endif
         end
      end
   end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// fft_sdf_ctrl: handshake, stage control and valid tracking for an SDF FFT.
// Optional twiddle-address outputs under FFT_SDF_CTRL_TWIDDLE_EN.
module fft_sdf_ctrl
   import fft_pkg::*;
#(
   parameter int N_POINTS   = 16,
   parameter int NUM_STAGES = $clog2(N_POINTS),
   parameter int LOG2N      = $clog2(N_POINTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  m_ready,
   output logic                  stage_en,
   output logic [NUM_STAGES-1:0] stage_ctrl,
   output logic                  m_valid,
   output logic                  m_last,
   output logic                  busy,
   output logic                  frame_done
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
   ,
   output logic [LOG2N-1:0]      tw_addr [NUM_STAGES]
`endif
);
   localparam int TL = total_lat(N_POINTS);
   localparam int FW = $clog2(TL);
   localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N_POINTS - 1);
   localparam logic [FW-1:0]    FLUSH_END = FW'(TL - 1);

   state_t           state;
   logic [LOG2N-1:0] in_cnt;
   logic [LOG2N-1:0] out_cnt;
   logic [FW-1:0]    fcnt;
   logic [TL-1:0]    vsr;
   logic             adv;
   logic             accept;
   logic             flushing;
   logic             clr;

   // Handshake outputs are gated by reset so everything reads 0 in reset.
   assign flushing = (state == FLUSH);
   assign s_ready  = rst & m_ready & ~flushing;
   assign adv      = flushing ? (rst & m_ready) : (s_valid & s_ready);
   assign accept   = adv & ~flushing;
   assign stage_en = adv;
   assign m_valid  = adv & vsr[TL-1];
   assign m_last   = m_valid & (out_cnt == LAST_IDX);
   assign busy     = (state != IDLE);
   assign clr      = flushing & adv & (fcnt == FLUSH_END);

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      fft_stage_seq #(
         .N     (N_POINTS),
         .LOG2N (LOG2N),
         .S     (s)
      ) u_seq (
         .clk  (clk),
         .rst  (rst),
         .adv  (adv),
         .clr  (clr),
         .ctrl (stage_ctrl[s])
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
         ,
         .tw_addr (tw_addr[s])
`endif
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         in_cnt     <= '0;
         out_cnt    <= '0;
         fcnt       <= '0;
         vsr        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= m_last;
         if (adv)     vsr     <= {vsr[TL-2:0], accept};
         if (accept)  in_cnt  <= in_cnt + 1'b1;
         if (m_valid) out_cnt <= out_cnt + 1'b1;
         unique case (state)
            IDLE: begin
               if (accept) state <= RUN;
            end
            RUN: begin
               // in_cnt back at 0 means a whole frame is in; a gap here ends the stream.
               if (in_cnt == '0 && !s_valid) begin
                  state <= FLUSH;
                  fcnt  <= '0;
               end
            end
            FLUSH: begin
               if (adv) begin
                  if (fcnt == FLUSH_END) begin
                     state <= IDLE;
                     fcnt  <= '0;
                  end else begin
                     fcnt <= fcnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb_fft_sdf_ctrl: directed and random stimulus checked against an advance-indexed model.
module tb_fft_sdf_ctrl;
   localparam int N  = 16;
   localparam int LG = 4;
   localparam int NS = 4;
   localparam int TL = 19;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic s_valid = 1'b0;
   logic m_ready = 1'b0;
   logic s_ready, stage_en, m_valid, m_last, busy, frame_done;
   logic [NS-1:0] stage_ctrl;
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
   logic [LG-1:0] tw_addr [NS];
`endif

   int errors = 0;
   int checks = 0;
   int mode, a, in_n, out_n, fl, mv_seen, ml_seen;
   bit real_q[$];
   bit prev_last;

   always #5 clk = ~clk;

   fft_sdf_ctrl #(.N_POINTS(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_ready    (m_ready),
      .stage_en   (stage_en),
      .stage_ctrl (stage_ctrl),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
      ,
      .tw_addr    (tw_addr)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples stage s has counted after adv advances of the current stream.
   function automatic int pos_of(input int s, input int adv);
      int d;
      d = 0;
      for (int i = 0; i < s; i++) d += (N >> (i + 1)) + 1;
      return (adv > d) ? (adv - d) % N : 0;
   endfunction

   task automatic model_reset();
      mode = 0; a = 0; in_n = 0; out_n = 0; fl = 0;
      real_q.delete();
      prev_last = 1'b0;
   endtask

   task automatic tick(input bit sv, input bit mr);
      bit er, ee, emv, eml, ec;
      int p, etw;
      s_valid = sv;
      m_ready = mr;
      #3;
      er  = mr && (mode != 2);
      ee  = (mode == 2) ? mr : (sv && er);
      emv = 1'b0;
      if (ee && a >= TL) emv = real_q[a - TL];
      eml = emv && (out_n % N == N - 1);
      chk("s_ready", 32'(s_ready), 32'(er));
      chk("stage_en", 32'(stage_en), 32'(ee));
      chk("m_valid", 32'(m_valid), 32'(emv));
      chk("m_last", 32'(m_last), 32'(eml));
      chk("busy", 32'(busy), 32'(mode != 0));
      chk("frame_done", 32'(frame_done), 32'(prev_last));
      for (int s = 0; s < NS; s++) begin
         p  = pos_of(s, a);
         ec = ((p >> (LG - 1 - s)) & 1) != 0;
         chk("stage_ctrl", 32'(stage_ctrl[s]), 32'(ec));
         etw = ec ? ((p % (N >> (s + 1))) << s) % N : 0;
`ifdef FFT_SDF_CTRL_TWIDDLE_EN
         chk("tw_addr", 32'(tw_addr[s]), 32'(etw));
`endif
      end
      if (m_valid === 1'b1) mv_seen++;
      if (m_last === 1'b1) ml_seen++;
      if (ee) begin
         real_q.push_back(mode != 2);
         a++;
         if (mode != 2) in_n++;
         if (emv) out_n++;
      end
      if (mode == 0 && ee) begin
         mode = 1;
      end else if (mode == 1 && in_n % N == 0 && !sv) begin
         mode = 2;
         fl = 0;
      end else if (mode == 2 && ee) begin
         fl++;
         if (fl == TL) begin
            mode = 0; a = 0; in_n = 0; fl = 0;
            real_q.delete();
         end
      end
      prev_last = eml;
      @(posedge clk);
      #1;
   endtask

   task automatic finish_frame();
      int g;
      g = 0;
      while (in_n % N != 0 && g < 100) begin tick(1, 1); g++; end
      g = 0;
      while (mode != 0 && g < 200) begin tick(0, 1); g++; end
      tick(0, 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_stage_en"}, 32'(stage_en), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_m_last"}, 32'(m_last), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_stage_ctrl"}, 32'(stage_ctrl), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      int k, g;
      model_reset();
      mv_seen = 0;
      ml_seen = 0;
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      s_valid = 1'b1;
      #1;
      check_all_zero("reset");
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single frame
      mv_seen = 0; ml_seen = 0;
      repeat (N) tick(1, 1);
      finish_frame();
      chk("frame1_outputs", 32'(mv_seen), 32'(N));
      chk("frame1_last", 32'(ml_seen), 32'd1);

      // Three back-to-back frames
      mv_seen = 0; ml_seen = 0;
      repeat (3 * N) tick(1, 1);
      finish_frame();
      chk("b2b_outputs", 32'(mv_seen), 32'(3 * N));
      chk("b2b_last", 32'(ml_seen), 32'd3);

      // Mid-frame input gap
      mv_seen = 0;
      repeat (7) tick(1, 1);
      repeat (5) tick(0, 1);
      repeat (N - 7) tick(1, 1);
      finish_frame();
      chk("gap_outputs", 32'(mv_seen), 32'(N));

      // Backpressure during flush stretches it
      repeat (N) tick(1, 1);
      tick(0, 1);
      k = 0;
      repeat (4) begin tick(0, 1); k++; end
      repeat (3) begin tick(0, 0); k++; end
      g = 0;
      while (busy === 1'b1 && g < 60) begin tick(0, 1); k++; g++; end
      chk("flush_cycles", 32'(k), 32'(TL + 3));
      tick(0, 1);

      // Input held off during flush, accepted once idle
      repeat (N) tick(1, 1);
      tick(0, 1);
      repeat (25) tick(1, 1);
      finish_frame();

      // Reset in the middle of a frame
      repeat (10) tick(1, 1);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      mv_seen = 0; ml_seen = 0;
      repeat (N) tick(1, 1);
      finish_frame();
      chk("postrst_outputs", 32'(mv_seen), 32'(N));
      chk("postrst_last", 32'(ml_seen), 32'd1);

      // Random valid/ready traffic
      repeat (600) tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      finish_frame();
      chk("final_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
